// File: rtl/led_div_ctrl.sv
// Button-debounced divider stepper with PS override for the LED counter partition.
// Produces a registered 5-bit divider value and a one-cycle write strobe.
module led_div_ctrl #(
  parameter int unsigned DEB_CYC = 1000000,
  parameter int          DIV_MIN = 0,
  parameter int          DIV_MAX = 31,
  parameter int          DIV_RST = 24
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic       btn_i,
  input  logic       dir_i,
  input  logic [4:0] ps_div_i,
  input  logic       ps_wr_i,
  output logic [4:0] div_o,
  output logic       wren_o,
  output logic       busy_o
);

  localparam int unsigned DIV_W = 5;
  localparam int unsigned CNT_W = $clog2(DEB_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEB_PR  = 2'd1,
    HELD    = 2'd2,
    DEB_REL = 2'd3
  } state_e;

  state_e             state_q;
  logic [1:0]         sync_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DIV_W-1:0]   div_q;
  logic               wren_q;
  logic               busy_q;
  logic               load_q;
  logic [DIV_W-1:0]   step_div_d;
  logic               btn_s;

  assign btn_s = sync_q[1];

  // Next divider value for a button step; out-of-range values wrap toward the range.
  always_comb begin
    step_div_d = div_q;
    if (dir_i) begin
      if (int'(div_q) >= DIV_MAX) step_div_d = DIV_W'(DIV_MIN);
      else                        step_div_d = div_q + DIV_W'(1);
    end else begin
      if (int'(div_q) <= DIV_MIN) step_div_d = DIV_W'(DIV_MAX);
      else                        step_div_d = div_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      div_q   <= DIV_W'(DIV_RST);
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      load_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      load_q <= 1'b0;
      // load_q makes downstream latch the reset value once after reset
      wren_q <= load_q | ps_wr_i;
      if (ps_wr_i) div_q <= ps_div_i;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (btn_s) begin
            state_q <= DEB_PR;
            busy_q  <= 1'b1;
          end
        end
        DEB_PR: begin
          if (!btn_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HELD;
            cnt_q   <= '0;
            // a coincident PS write wins and the step is dropped
            if (!ps_wr_i) begin
              div_q  <= step_div_d;
              wren_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          cnt_q <= '0;
          if (!btn_s) state_q <= DEB_REL;
        end
        DEB_REL: begin
          if (btn_s) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign div_o  = div_q;
  assign wren_o = wren_q;
  assign busy_o = busy_q;

endmodule
